// File: rtl/spike_cnt_pkg.sv
// Shared constants and helpers for the spike window counter.
package spike_cnt_pkg;

   localparam int CNT_W_DEF    = 16;
   localparam int WIN_LOG2_DEF = 4;
   localparam int OUT_W        = 32;

   // Saturating increment on a zero-extended value; callers truncate to their width.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val,
                                           input logic        inc);
      logic [31:0] res;
      if (inc && (val != max_val)) begin
         res = val + 32'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/spike_win_ring.sv
// Ring of the last 2^DEPTH_LOG2 step counts with write pointer and fill tracking.
module spike_win_ring
   import spike_cnt_pkg::*;
#(
   parameter int DEPTH_LOG2 = WIN_LOG2_DEF,
   parameter int W          = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         full
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int FILL_W = DEPTH_LOG2 + 1;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

   logic [W-1:0]            ring_r [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_r;
   logic [FILL_W-1:0]       fill_r;
   logic                    full_r;

   // Oldest entry is read from the slot about to be overwritten (pre-write value).
   assign rd_data = ring_r[wr_ptr_r];
   assign full    = full_r;

   // Ring storage and write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ring_r[i] <= {W{1'b0}};
         wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) ring_r[i] <= {W{1'b0}};
         wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      end else if (wr_en) begin
         ring_r[wr_ptr_r] <= wr_data;
         wr_ptr_r         <= wr_ptr_r + DEPTH_LOG2'(1);
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Fill counter stops at the ring depth; full flag is registered alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_r <= {FILL_W{1'b0}};
         full_r <= 1'b0;
      end else if (clr) begin
         fill_r <= {FILL_W{1'b0}};
         full_r <= 1'b0;
      end else if (wr_en && (fill_r != FILL_MAX)) begin
         fill_r <= fill_r + FILL_W'(1);
         full_r <= ((fill_r + FILL_W'(1)) == FILL_MAX);
      end else begin
         fill_r <= fill_r;
         full_r <= full_r;
      end
   end

endmodule

// File: rtl/spike_window_counter.sv
// Per-step spike counter with optional sliding-window sum (enabled by SPIKE_CNT_WINDOW_EN).
module spike_window_counter
   import spike_cnt_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             spike_in,
   input  logic             tick,
   input  logic             clear,
   output logic [OUT_W-1:0] step_cnt_out,
   output logic [OUT_W-1:0] win_sum_out,
   output logic             out_valid,
   output logic             win_full
);

   localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

   if ((WIN_LOG2 < 1) || (WIN_LOG2 > 6)) begin : g_bad_win
      $error("spike_window_counter: WIN_LOG2 out of range 1..6");
   end

   logic [CNT_W-1:0] acc_r;
   logic [CNT_W-1:0] acc_inc_s;
   logic [OUT_W-1:0] step_cnt_r;
   logic             valid_r;

   // acc + spike_in with saturation; on a tick this is the closing count.
   assign acc_inc_s = CNT_W'(sat_inc(OUT_W'(acc_r), OUT_W'(ACC_MAX), spike_in));

   // Accumulator and per-step output registers; clear outranks tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_r      <= {CNT_W{1'b0}};
         step_cnt_r <= {OUT_W{1'b0}};
         valid_r    <= 1'b0;
      end else if (clear) begin
         acc_r      <= {CNT_W{1'b0}};
         step_cnt_r <= {OUT_W{1'b0}};
         valid_r    <= 1'b0;
      end else if (tick) begin
         acc_r      <= {CNT_W{1'b0}};
         step_cnt_r <= OUT_W'(acc_inc_s);
         valid_r    <= 1'b1;
      end else begin
         acc_r      <= acc_inc_s;
         step_cnt_r <= step_cnt_r;
         valid_r    <= 1'b0;
      end
   end

   assign step_cnt_out = step_cnt_r;
   assign out_valid    = valid_r;

`ifdef SPIKE_CNT_WINDOW_EN
   localparam int SUM_W = CNT_W + WIN_LOG2;

   logic [CNT_W-1:0] old_s;
   logic             full_s;
   logic [SUM_W-1:0] win_sum_r;

   spike_win_ring #(
      .DEPTH_LOG2 (WIN_LOG2),
      .W          (CNT_W)
   ) u_ring (
      .clk     (clk),
      .rst_n   (reset_n),
      .clr     (clear),
      .wr_en   (tick),
      .wr_data (acc_inc_s),
      .rd_data (old_s),
      .full    (full_s)
   );

   // Running window sum; unfilled slots read as zero so no fill special case.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_sum_r <= {SUM_W{1'b0}};
      end else if (clear) begin
         win_sum_r <= {SUM_W{1'b0}};
      end else if (tick) begin
         win_sum_r <= win_sum_r + SUM_W'(acc_inc_s) - SUM_W'(old_s);
      end else begin
         win_sum_r <= win_sum_r;
      end
   end

   assign win_sum_out = OUT_W'(win_sum_r);
   assign win_full    = full_s;
`else
   assign win_sum_out = {OUT_W{1'b0}};
   assign win_full    = 1'b0;
`endif

endmodule

// File: tb/tb_spike_window_counter.sv
// Randomized bench for spike_window_counter against a step-history reference model.
module tb_spike_window_counter;

`ifdef SPIKE_CNT_WINDOW_EN
   localparam bit WIN_EN = 1'b1;
`else
   localparam bit WIN_EN = 1'b0;
`endif
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        spike_in = 1'b0;
   logic        tick = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] step_a, win_a, step_b, win_b;
   logic        valid_a, full_a, valid_b, full_b;

   always #5 clk = ~clk;

   spike_window_counter dut (
      .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .tick(tick), .clear(clear),
      .step_cnt_out(step_a), .win_sum_out(win_a), .out_valid(valid_a), .win_full(full_a)
   );

   spike_window_counter #(.CNT_W(4), .WIN_LOG2(4)) dut_sat (
      .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .tick(tick), .clear(clear),
      .step_cnt_out(step_b), .win_sum_out(win_b), .out_valid(valid_b), .win_full(full_b)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: per-instance open-step count plus history of closed steps.
   int maxv [2] = '{65535, 15};
   int acc_m [2];
   int step_m [2];
   bit valid_m;
   int hist0 [$];
   int hist1 [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int qsum(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   function automatic int sat_add(input int a, input int b, input int m);
      return (a + b > m) ? m : a + b;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         acc_m[i]  = 0;
         step_m[i] = 0;
      end
      valid_m = 1'b0;
      hist0.delete();
      hist1.delete();
   endtask

   task automatic model_edge(input bit sp, input bit tk, input bit cl);
      int c;
      if (cl) begin
         model_clear();
      end else if (tk) begin
         for (int i = 0; i < 2; i++) begin
            c = sat_add(acc_m[i], int'(sp), maxv[i]);
            step_m[i] = c;
            acc_m[i]  = 0;
            if (i == 0) hist0.push_back(c); else hist1.push_back(c);
         end
         if (hist0.size() > DEPTH) void'(hist0.pop_front());
         if (hist1.size() > DEPTH) void'(hist1.pop_front());
         valid_m = 1'b1;
      end else begin
         for (int i = 0; i < 2; i++) acc_m[i] = sat_add(acc_m[i], int'(sp), maxv[i]);
         valid_m = 1'b0;
      end
   endtask

   task automatic check_all();
      check_val("step_a",  step_a,  32'(step_m[0]));
      check_val("valid_a", 32'(valid_a), 32'(valid_m));
      check_val("win_a",   win_a,   WIN_EN ? 32'(qsum(hist0)) : 32'd0);
      check_val("full_a",  32'(full_a), (WIN_EN && hist0.size() >= DEPTH) ? 32'd1 : 32'd0);
      check_val("step_b",  step_b,  32'(step_m[1]));
      check_val("valid_b", 32'(valid_b), 32'(valid_m));
      check_val("win_b",   win_b,   WIN_EN ? 32'(qsum(hist1)) : 32'd0);
      check_val("full_b",  32'(full_b), (WIN_EN && hist1.size() >= DEPTH) ? 32'd1 : 32'd0);
   endtask

   task automatic cycle(input bit sp, input bit tk, input bit cl);
      @(negedge clk);
      spike_in = sp;
      tick     = tk;
      clear    = cl;
      @(posedge clk);
      model_edge(sp, tk, cl);
      #1;
      check_all();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
   task automatic pulse_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      spike_in = 1'b0;
      tick = 1'b0;
      clear = 1'b0;
      model_clear();
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      model_clear();
      #12;
      pulse_reset();
      check_val("reset_step", step_a, 32'd0);

      // Idle steps: three ticks with no spikes.
      for (int t = 0; t < 3; t++) begin
         cycle(1'b0, 1'b0, 1'b0);
         cycle(1'b0, 1'b1, 1'b0);
         check_val("idle_valid", 32'(valid_a), 32'd1);
      end
      cycle(1'b0, 1'b0, 1'b0);

      // Boundary spikes around the tick.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      check_val("boundary_6", step_a, 32'd6);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      check_val("boundary_1", step_a, 32'd1);

      // Window slide: step k carries k spikes.
      pulse_reset();
      for (int k = 1; k <= 20; k++) begin
         for (int s = 1; s < k; s++) cycle(1'b1, 1'b0, 1'b0);
         cycle(1'b1, 1'b1, 1'b0);
         if (k == 15) check_val("full_at_15", 32'(full_a), 32'd0);
         if (k == 16) begin
            check_val("win_at_16",  win_a, WIN_EN ? 32'd136 : 32'd0);
            check_val("full_at_16", 32'(full_a), WIN_EN ? 32'd1 : 32'd0);
         end
      end
      check_val("win_at_20", win_a, WIN_EN ? 32'd200 : 32'd0);

      // Saturation of the narrow instance; next step restarts from zero.
      for (int i = 0; i < 19; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      check_val("sat_15", step_b, 32'd15);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      check_val("sat_next", step_b, 32'd1);

      // Clear together with tick discards the step.
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      check_val("clr_valid", 32'(valid_a), 32'd0);
      check_val("clr_step", step_a, 32'd0);
      cycle(1'b0, 1'b1, 1'b0);
      check_val("clr_after", step_a, 32'd0);

      // Reset mid-step loses the partial count.
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
      pulse_reset();
      cycle(1'b0, 1'b1, 1'b0);
      check_val("rst_after", step_a, 32'd0);

      // Randomized traffic including back-to-back ticks, clears and resets.
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (r < 4) begin
            pulse_reset();
         end else begin
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 999) < 8));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spike_window_counter.md
# spike_window_counter

Counts raw spikes from a neuron population on the neuron clock and presents them to the muscle stage once per simulation step. Each simulation step yields the latched spike count for that step and a sliding-window sum over the last 2^WIN_LOG2 steps. The block sits between the neuron's raw spike output and the muscle model's spike-count input, and replaces free-running counters whose value is sampled across an asynchronous boundary.

## Interface
- CNT_W, default 16: width of the per-step counter; the counter saturates at 2^CNT_W-1.
- WIN_LOG2, default 4: window depth is 2^WIN_LOG2 steps (16). Legal range is 1..6.
- clk  input  1  neuron clock; all logic is on this clock.
- reset_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- spike_in  input  1  raw spike, one-cycle pulse, sampled every clk.
- tick  input  1  one-cycle strobe that closes the current simulation step, synchronous to clk.
- clear  input  1  synchronous flush of counter, window and fill state.
- step_cnt_out  output  32  spike count of the last completed step, zero-extended.
- win_sum_out  output  32  sum of the last 2^WIN_LOG2 step counts, zero-extended.
- out_valid  output  1  one-cycle pulse when the outputs update.
- win_full  output  1  high once 2^WIN_LOG2 steps have been recorded since reset/clear.

## Operation
- Accumulator acc (CNT_W bits) increments on every clk with spike_in=1 and saturates at all-ones.
- When tick=1 in cycle T, the closing count is c = acc + spike_in (saturating). A spike in the tick cycle belongs to the closing step.
- At the edge ending cycle T:
  - step_cnt_out <= c.
  - The oldest ring entry old is read from ring[wr_ptr].
  - ring[wr_ptr] <= c; win_sum <= win_sum + c - old.
  - wr_ptr increments mod 2^WIN_LOG2.
  - acc <= 0.
  - out_valid pulses.
- win_sum width is CNT_W+WIN_LOG2 and can never overflow. Unfilled ring entries are zero, so the subtraction needs no fill-state special case.
- win_full: fill counter counts ticks and stops at 2^WIN_LOG2; win_full=1 when it reaches the limit.
- clear=1 acts like reset at the next edge:
  - acc, ring, wr_ptr, win_sum, fill counter and outputs go to 0; out_valid=0.
  - clear has priority over tick and spike_in in the same cycle, so that step is discarded.
- reset_n low at any time, including mid-step: all state clears immediately and the partial count is lost.
- Reset values of all outputs: step_cnt_out=0, win_sum_out=0, out_valid=0, win_full=0.
- Back-to-back ticks (tick high in consecutive cycles) are legal. A step may contain 0 spikes, or 1 if spike_in coincides with the tick.

## Timing
- Latency is 1 clk: the outputs and out_valid are registered at the edge ending the tick cycle.
- The outputs hold between ticks.
- A spike in cycle T+1 (after the tick) counts toward the next step.
- No backpressure: the consumer samples on out_valid or on the next sim_clk edge. Outputs are stable for the whole step.
- Ring read and write happen on the same edge; the read uses the pre-write value (read-before-write).

## Configuration
- SPIKE_CNT_WINDOW_EN defined:
  - The ring buffer, win_sum and fill logic are built.
  - win_sum_out and win_full behave as above.
- SPIKE_CNT_WINDOW_EN undefined:
  - No ring or window logic.
  - win_sum_out is tied to 0 and win_full is tied to 0.
  - step_cnt_out, out_valid and clear behave identically to the defined case.

## Structure
- Shared package spike_cnt_pkg holds:
  - default CNT_W and WIN_LOG2;
  - the 32-bit output width constant;
  - a saturating-increment function used by acc.
- One sub-module, spike_win_ring:
  - parameterised depth and width;
  - register array with async-low reset and sync clear;
  - single write port with read-before-write of the same index;
  - owns wr_ptr and the fill counter.
- The top level holds acc, win_sum and the output registers.

## Test plan
- Reset and idle: reset_n low then released, no stimulus, 3 ticks -> all outputs 0; out_valid pulses 3 times, 1 cycle after each tick.
- Boundary spike: 5 spikes in a step, plus one spike in the tick cycle, plus one spike in the cycle after the tick -> step_cnt_out=6 for that step; the following step reports 1 if no further spikes.
- Window slide: 20 ticks with step k carrying k spikes (k=1..20) -> win_full rises after tick 16; win_sum_out after tick 16 is 136; after tick 20 it is 200 (sum 5..20).
- Saturation: CNT_W=4, 20 spikes in one step -> step_cnt_out=15; the next step starts from 0.
- Clear/reset priority: clear asserted together with tick after 7 spikes -> outputs 0, out_valid stays low, win_full=0; reset_n pulsed mid-step gives the same result.
- Macro off: build without SPIKE_CNT_WINDOW_EN, repeat the window-slide scenario -> step_cnt_out matches; win_sum_out=0 and win_full=0 throughout.
